// File: rtl/led_pulser_pkg.sv
// Shared types and elaboration helpers for the LED/buzzer pulse stretcher.
package led_pulser_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StOn   = 1'b1
  } state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/led_pulser_if.sv
// Event inputs from the game FSM and pin drives of the pulse stretcher.
interface led_pulser_if #(
  parameter int unsigned CHANNELS = 5
) ();

  logic [CHANNELS-1:0] trig;
  logic                cancel;
  logic [CHANNELS-1:0] led;
  logic [CHANNELS-1:0] busy;

  modport master (
    output trig,
    output cancel,
    input  led,
    input  busy
  );

  modport slave (
    input  trig,
    input  cancel,
    output led,
    output busy
  );

endinterface

// File: rtl/led_pulser_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, at count DIV-1.
module tick_gen
  import led_pulser_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CntW'(DIV - 1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntW'(DIV - 1));

endmodule

// File: rtl/led_pulser.sv
// Per-channel pulse stretcher for LEDs/buzzer; hold time counted in slow ticks.
// Optional blinking while on is enabled by defining LED_PULSER_BLINK_EN.
module led_pulser
  import led_pulser_pkg::*;
#(
  parameter int unsigned CHANNELS    = 5,
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned HOLD_TICKS  = 250,
  parameter int unsigned BLINK_TICKS = 50
) (
  input logic         clk,
  input logic         reset_n,
  led_pulser_if.slave pins
);

  localparam int unsigned Div   = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned HoldW = cnt_width(HOLD_TICKS);

  if (Div < 2 || HOLD_TICKS < 1 || BLINK_TICKS < 1) begin : g_bad_params
    $error("led_pulser: illegal parameter combination");
  end

  logic                tick;
  logic [CHANNELS-1:0] led_vec;
  logic [CHANNELS-1:0] busy_vec;

  tick_gen #(
    .DIV (Div)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e           state_q;
    logic [HoldW-1:0] hold_q;
    logic             led_q;
    logic             busy_q;
`ifdef LED_PULSER_BLINK_EN
    localparam int unsigned BlinkW = cnt_width(BLINK_TICKS);
    logic [BlinkW-1:0] blink_q;
    logic              phase_q;
`endif

    // Priority: cancel, then trig (reload), then tick countdown.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= StIdle;
        hold_q  <= '0;
        led_q   <= 1'b0;
        busy_q  <= 1'b0;
`ifdef LED_PULSER_BLINK_EN
        blink_q <= '0;
        phase_q <= 1'b0;
`endif
      end else if (pins.cancel) begin
        state_q <= StIdle;
        hold_q  <= '0;
        led_q   <= 1'b0;
        busy_q  <= 1'b0;
`ifdef LED_PULSER_BLINK_EN
        blink_q <= '0;
        phase_q <= 1'b0;
`endif
      end else if (pins.trig[i]) begin
        state_q <= StOn;
        hold_q  <= HoldW'(HOLD_TICKS);
        led_q   <= 1'b1;
        busy_q  <= 1'b1;
`ifdef LED_PULSER_BLINK_EN
        blink_q <= BlinkW'(BLINK_TICKS);
        phase_q <= 1'b1;
`endif
      end else if (state_q == StOn && tick) begin
        if (hold_q == HoldW'(1)) begin
          state_q <= StIdle;
          hold_q  <= '0;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end else begin
          hold_q <= hold_q - 1'b1;
`ifdef LED_PULSER_BLINK_EN
          // The first (partial) tick after a load only arms the blink counter.
          if (blink_q == '0) begin
            blink_q <= BlinkW'(BLINK_TICKS - 1);
            phase_q <= ~phase_q;
            led_q   <= ~phase_q;
          end else begin
            blink_q <= blink_q - 1'b1;
          end
`endif
        end
      end
    end

    assign led_vec[i]  = led_q;
    assign busy_vec[i] = busy_q;
  end

  assign pins.led  = led_vec;
  assign pins.busy = busy_vec;

endmodule

// File: doc/led_pulser.md
# led_pulser

Output-side counterpart to the button debouncer, driving the Bopit LEDs and buzzer. It turns clean single-cycle event pulses from the game logic into human-visible, fixed-duration outputs. Each channel holds its output for a programmable number of slow ticks, with optional blinking. It sits between the game FSM and the LED/buzzer pins, one channel per button.

## Interface

Parameters:
- `CHANNELS`, default 5: number of independent output channels.
- `CLK_HZ`, default 100_000_000: system clock frequency.
- `TICK_HZ`, default 1000: slow tick rate. `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `HOLD_TICKS`, default 250: output hold time in ticks, ≥ 1.
- `BLINK_TICKS`, default 50: blink half-period in ticks, ≥ 1. Only used with `LED_PULSER_BLINK_EN`.

Ports:
- `clk`, input, 1: system clock. One clock domain.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `trig`, input, CHANNELS: single-cycle start/retrigger pulse per channel, synchronous to `clk`.
- `cancel`, input, 1: single-cycle pulse that clears all channels.
- `led`, output, CHANNELS: registered drive to the pins.
- `busy`, output, CHANNELS: registered, high while the channel is in ON.

## Operation

- Prescaler: a free-running counter `0..DIV-1`. `tick` is high for the one cycle in which the counter equals `DIV-1`. The prescaler is never reset by `trig` or `cancel`.
- Each channel has a 2-state FSM (IDLE, ON), a hold counter of width `$clog2(HOLD_TICKS+1)`, and an output register.
- IDLE to ON on `trig[i]`:
  - load the counter with `HOLD_TICKS`;
  - set `led[i]=1` and `busy[i]=1`.
- While in ON, on each `tick` the counter decrements. On the tick where the counter goes 1 to 0, the channel returns to IDLE and clears `led[i]` and `busy[i]` on the same edge.
- Retrigger: `trig[i]` while in ON reloads `HOLD_TICKS` and stays in ON (restart, not extend).
- Simultaneous events, by priority:
  - `cancel` beats `trig`: all channels go to IDLE with outputs 0, and a coincident `trig` is dropped.
  - `trig` beats `tick`: the reload wins.
- Channels are fully independent. Any combination of `trig` bits may assert in one cycle.
- Reset (any time, including mid-hold): all FSMs go to IDLE, counters and prescaler to 0, and `led`/`busy` to 0.

## Timing

- Latency from `trig` sampled at edge N to `led` high after edge N: 1 cycle (registered).
- Hold duration is `(HOLD_TICKS-1)*DIV+1` to `HOLD_TICKS*DIV` cycles, depending on the prescaler phase at trigger.
- `cancel` takes effect at the next edge, so outputs are low 1 cycle after `cancel` is sampled.
- `busy` is cycle-aligned with the ON state in both configurations.

## Configuration

- Macro: `LED_PULSER_BLINK_EN`.
- Defined:
  - each channel carries a blink counter and phase bit;
  - the phase is forced to 1 on load or reload;
  - the phase toggles every `BLINK_TICKS` ticks while in ON;
  - `led[i] = phase & ON`, while `busy` is unchanged.
- Undefined: `led[i]` equals `busy[i]` (steady on), and no blink logic is synthesized.

## Structure

- Shared package `led_pulser_pkg` holds:
  - the state encoding (IDLE=0, ON=1);
  - the `DIV` computation;
  - the counter-width helper.
- One sub-module, `tick_gen`: the prescaler, with `DIV` as its parameter, ports `clk`/`reset_n`, and output `tick`. Channel logic is a generate loop in `led_pulser`.

## Test plan

Bench parameters: `CLK_HZ=1000`, `TICK_HZ=100` (DIV=10), `HOLD_TICKS=4`, `BLINK_TICKS=1`. Reset is released before edge 0, and ticks fall at edges 9, 19, 29, 39.

- Basic hold: `trig[0]` at edge 5 → `led[0]`/`busy[0]` rise after edge 5 and fall at edge 39 (34 cycles high). Other channels stay 0.
- Retrigger: `trig[1]` at edge 5 and again at edge 25 → `led[1]` stays high continuously and falls at edge 59.
- Priority: `cancel` and `trig[2]` at edge 12, with channel 2 already ON → `led[2]=0` after edge 12. A later `trig[2]` at edge 20 restarts it and it falls at edge 59.
- Trigger on a tick edge: `trig[3]` at edge 9 → counter loads 4 (not 3) and `led[3]` falls at edge 49.
- Reset mid-hold: assert `reset_n=0` at cycle 15 with all channels ON → all `led`/`busy` are 0 immediately (asynchronous). After release, the first tick comes `DIV` cycles later.
- Blink, with `LED_PULSER_BLINK_EN` defined: `trig[4]` at edge 5 → `led[4]` is 1 for cycles 6–19, 0 for 20–29, 1 for 30–39, and 0 after edge 39. `busy[4]` is high for cycles 6–39.
